fsic_io_serdes_rx_deframer: RTL
===============================

# fsic_io_serdes_rx_deframer

Word-level deframer directly downstream of the io_serdes receive deserializer. It runs in the coreclk domain and takes one pCLK_RATIO-bit nibble per coreclk cycle. It locks onto the idle pattern, extracts parity-protected 32-bit payload words, and presents them on an AXI-Stream-style master port through a small output FIFO. It also reports lock state, error counts and overflow to the link control logic.

## Interface
- pCLK_RATIO, 4, nibble width; must equal the deserializer ratio (only 4 supported)
- pNIBBLES, 8, nibbles per payload word; word width = pCLK_RATIO*pNIBBLES = 32
- pLOCK_CNT, 8, consecutive idle nibbles required to acquire lock (2..255)
- pFIFO_DEPTH, 4, output FIFO entries; power of two, ≥2
- coreclk  in  1  sole clock; all logic on posedge
- axis_rst  in  1  reset, synchronous, active-high
- rxdata_in  in  pCLK_RATIO  nibble from deserializer, bit 0 = first serial bit
- rxdata_in_valid  in  1  deserializer running; level signal, not a per-nibble strobe
- m_tdata  out  32  payload word, nibble 0 in bits [3:0]
- m_tvalid  out  1  FIFO non-empty
- m_tready  in  1  consumer accepts m_tdata
- locked  out  1  deframer in lock
- err_cnt  out  8  saturating count of framing and parity errors
- overflow  out  1  sticky; a word was dropped on a full FIFO

## Operation
- Codes: IDLE = 4'hA, SOF = 4'h5. Frame format: SOF, then pNIBBLES payload nibbles (LSB nibble first), then CHK = XOR of the payload nibbles.
- When rxdata_in_valid=0, nothing is sampled: the FSM is forced to HUNT, the lock counter is cleared, and the partial word is discarded. FIFO and counters are kept.
- HUNT:
  - IDLE nibble → lock_cnt+1. Any other nibble → lock_cnt=0.
  - When lock_cnt reaches pLOCK_CNT → LOCKED, locked=1.
- LOCKED:
  - IDLE → stay.
  - SOF → PAYLOAD, with nib_idx=0 and parity accumulator cleared.
  - Any other value → err_cnt+1, go to HUNT, locked=0.
- PAYLOAD:
  - Store the nibble at word[4*nib_idx+:4] and XOR it into parity.
  - After nib_idx = pNIBBLES-1 → CHECK.
- CHECK:
  - CHK equal to parity → push the word into the FIFO.
  - CHK not equal → drop the word, err_cnt+1.
  - Either way → LOCKED. A parity error does not drop lock.
- Push when the FIFO is full and there is no simultaneous pop → word dropped, overflow=1 (cleared only by reset).
- Push and pop in the same cycle on a full FIFO → both performed; no overflow.
- FIFO pop on m_tvalid & m_tready. Pointers wrap modulo pFIFO_DEPTH. Full/empty use one extra pointer bit.
- err_cnt saturates at 8'hFF.

## Timing
- Reset values: m_tdata=0, m_tvalid=0, locked=0, err_cnt=0, overflow=0; FSM=HUNT; FIFO empty.
- Reset asserted mid-frame → all state restored at the next posedge; in-flight words are lost.
- Lock latency: locked rises on the edge that samples the pLOCK_CNT-th consecutive IDLE.
- Word latency: CHK is sampled at edge N. The FIFO write happens at edge N. m_tvalid=1 after edge N if the FIFO was empty.
- Frame length: 1+pNIBBLES+1 = 10 cycles. Back-to-back frames (SOF immediately after CHK) are legal, giving 1 word per 10 cycles at maximum.
- m_tdata is valid and stable while m_tvalid=1 and m_tready=0. m_tvalid must not depend combinationally on m_tready.
- locked falls on the edge that samples an illegal nibble in LOCKED, or on the first edge with rxdata_in_valid=0.

## Configuration
- FSIC_RX_DEFRAMER_PARITY_EN defined:
  - Frame includes the CHK nibble; CHECK state behaves as above.
- Not defined:
  - No CHK nibble and no CHECK state.
  - The word is pushed at the edge sampling payload nibble pNIBBLES-1; FSM then → LOCKED.
  - Frame = 9 cycles. err_cnt counts framing errors only.

## Test plan
- Lock acquisition: 8×IDLE, then SOF, nibbles 1..8, CHK=4'h8 → locked=1 after the 8th IDLE; m_tdata=32'h87654321; m_tvalid=1 the cycle after CHK.
- Bad parity: locked, SOF, 8×4'hF, CHK=4'h1 → no push, err_cnt=1, locked remains 1.
- Framing error: locked, nibble 4'h3 in LOCKED → locked=0, err_cnt=1; relock after 8 IDLE.
- Backpressure/overflow: m_tready=0, 5 valid frames with pFIFO_DEPTH=4 → 4 words held in order, overflow=1; then m_tready=1 → drains the 4 words in order.
- Full push+pop: FIFO full, m_tready=1 on the CHK cycle → push and pop both performed, overflow stays 0.
- Disruption: drop rxdata_in_valid mid-PAYLOAD, or pulse axis_rst mid-frame → partial word discarded, FSM=HUNT; on reset, all outputs return to reset values.

Source files
------------

// File: rtl/fsic_io_serdes_rx_deframer.sv
// fsic_io_serdes_rx_deframer: locks onto IDLE nibbles, extracts 32-bit payload words and streams them out via a small FIFO
// Ports:
//   coreclk          sole clock, posedge
//   axis_rst         synchronous active-high reset
//   rxdata_in        nibble from deserializer, bit 0 first serial bit
//   rxdata_in_valid  deserializer running (level)
//   m_tdata/m_tvalid/m_tready  AXI-Stream style master, m_tvalid = FIFO non-empty
//   locked           deframer in lock
//   err_cnt          saturating framing/parity error count
//   overflow         sticky, a word was dropped on a full FIFO
// Build option: FSIC_RX_DEFRAMER_PARITY_EN adds the CHK nibble and CHECK state.
module fsic_io_serdes_rx_deframer #(
    parameter int pCLK_RATIO  = 4,
    parameter int pNIBBLES    = 8,
    parameter int pLOCK_CNT   = 8,
    parameter int pFIFO_DEPTH = 4
) (
    input  logic                           coreclk,
    input  logic                           axis_rst,
    input  logic [pCLK_RATIO-1:0]          rxdata_in,
    input  logic                           rxdata_in_valid,
    output logic [pCLK_RATIO*pNIBBLES-1:0] m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           locked,
    output logic [7:0]                     err_cnt,
    output logic                           overflow
);
    localparam int W  = pCLK_RATIO * pNIBBLES;
    localparam int AW = $clog2(pFIFO_DEPTH);
    localparam int NW = pNIBBLES > 1 ? $clog2(pNIBBLES) : 1;
    localparam logic [pCLK_RATIO-1:0] IDLE_NIB = pCLK_RATIO'('hA);
    localparam logic [pCLK_RATIO-1:0] SOF_NIB  = pCLK_RATIO'('h5);
    localparam logic [7:0]            LOCK_LAST = 8'(pLOCK_CNT - 1);
    localparam logic [NW-1:0]         NIB_LAST  = NW'(pNIBBLES - 1);

`ifdef FSIC_RX_DEFRAMER_PARITY_EN
    typedef enum logic [1:0] {HUNT, LOCKED, PAYLOAD, CHECK} state_t;
    logic [pCLK_RATIO-1:0] parity;
`else
    typedef enum logic [1:0] {HUNT, LOCKED, PAYLOAD} state_t;
`endif

    state_t          state, state_nxt;
    logic [7:0]      lock_cnt;
    logic [NW-1:0]   nib_idx;
    logic [W-1:0]    word, word_nxt, push_word;
    logic            is_idle, is_sof, nib_last;
    logic            frame_err, par_err, push_req, do_push, pop, full, empty;
    logic [W-1:0]    mem [pFIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;

    assign is_idle  = rxdata_in == IDLE_NIB;
    assign is_sof   = rxdata_in == SOF_NIB;
    assign nib_last = nib_idx == NIB_LAST;
    assign locked   = state != HUNT;

    always_ff @(posedge coreclk) begin
        if (axis_rst) state <= HUNT;
        else          state <= state_nxt;
    end

    // Losing the deserializer overrides everything and sends the FSM back to hunting.
    always_comb begin
        state_nxt = state;
        if (!rxdata_in_valid) state_nxt = HUNT;
        else begin
            case (state)
                HUNT:    state_nxt = (is_idle && lock_cnt == LOCK_LAST) ? LOCKED : HUNT;
                LOCKED:  state_nxt = is_idle ? LOCKED : is_sof ? PAYLOAD : HUNT;
`ifdef FSIC_RX_DEFRAMER_PARITY_EN
                PAYLOAD: state_nxt = nib_last ? CHECK : PAYLOAD;
                CHECK:   state_nxt = LOCKED;
`else
                PAYLOAD: state_nxt = nib_last ? LOCKED : PAYLOAD;
`endif
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        frame_err = rxdata_in_valid && state == LOCKED && !is_idle && !is_sof;
        word_nxt  = word;
        word_nxt[pCLK_RATIO*nib_idx +: pCLK_RATIO] = rxdata_in;
`ifdef FSIC_RX_DEFRAMER_PARITY_EN
        par_err   = rxdata_in_valid && state == CHECK && rxdata_in != parity;
        push_req  = rxdata_in_valid && state == CHECK && rxdata_in == parity;
        push_word = word;
`else
        // Without a CHK nibble the word is pushed as its last nibble arrives.
        par_err   = 1'b0;
        push_req  = rxdata_in_valid && state == PAYLOAD && nib_last;
        push_word = word_nxt;
`endif
    end

    always_ff @(posedge coreclk) begin
        if (axis_rst || !rxdata_in_valid) begin
            lock_cnt <= '0;
            nib_idx  <= '0;
            word     <= '0;
`ifdef FSIC_RX_DEFRAMER_PARITY_EN
            parity   <= '0;
`endif
        end else begin
            lock_cnt <= (state == HUNT && is_idle && lock_cnt != LOCK_LAST) ? lock_cnt + 8'd1 : '0;
            nib_idx  <= (state == PAYLOAD && !nib_last) ? nib_idx + 1'b1 : '0;
            word     <= state == PAYLOAD ? word_nxt : word;
`ifdef FSIC_RX_DEFRAMER_PARITY_EN
            parity   <= state == PAYLOAD ? parity ^ rxdata_in : '0;
`endif
        end
    end

    always_ff @(posedge coreclk) begin
        if (axis_rst)                                    err_cnt <= '0;
        else if ((frame_err || par_err) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end

    // Extra pointer bit distinguishes full from empty.
    assign empty    = wr_ptr == rd_ptr;
    assign full     = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign m_tvalid = !empty;
    assign m_tdata  = m_tvalid ? mem[rd_ptr[AW-1:0]] : '0;
    assign pop      = m_tvalid && m_tready;
    assign do_push  = push_req && (!full || pop);

    always_ff @(posedge coreclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    always_ff @(posedge coreclk) begin
        if (axis_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end
endmodule
